// File: rtl/async_sink.sv
// async_sink: per-node NoC ejection sink; counts received/misrouted flits,
// throttles in_ready, and flags done after a quiet drain window. Rev 1.0
`default_nettype none

module async_sink #(
  parameter int NODE_ID       = 0,
  parameter int ADDR_W        = 4,
  parameter int FLIT_W        = 32,
  parameter int CNT_W         = 16,
  parameter int READY_GAP     = 0,
  parameter int COOLDOWN_IDLE = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              send,
  input  logic              in_valid,
  input  logic [FLIT_W-1:0] in_data,
  output logic              in_ready,
  output logic [CNT_W-1:0]  rx_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] last_src,
  output logic              done,
  output logic              late
);

  localparam int GAP_W   = (READY_GAP > 0) ? $clog2(READY_GAP + 1) : 1;
  localparam int QUIET_W = (COOLDOWN_IDLE > 1) ? $clog2(COOLDOWN_IDLE) : 1;

  localparam logic [GAP_W-1:0]   C_GAP        = GAP_W'(READY_GAP);
  localparam logic [QUIET_W-1:0] C_QUIET_LAST = QUIET_W'(COOLDOWN_IDLE - 1);
  localparam logic [CNT_W-1:0]   C_CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [ADDR_W-1:0]  C_NODE       = ADDR_W'(NODE_ID);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         r_state, w_state_next;
  logic [QUIET_W-1:0] r_quiet, w_quiet_next;
  logic [GAP_W-1:0]   r_gap, w_gap_next;

  logic              w_accept;
  logic              w_misroute;
  logic              w_quiet_hit;
  logic [ADDR_W-1:0] w_src;
  logic              unused_payload;

  assign w_accept       = in_valid & in_ready;
  assign w_misroute     = (in_data[ADDR_W-1:0] != C_NODE);
  assign w_src          = in_data[2*ADDR_W-1:ADDR_W];
  assign w_quiet_hit    = (r_quiet == C_QUIET_LAST);
  assign unused_payload = ^in_data[FLIT_W-1:2*ADDR_W];

  // Throttle: in_ready is registered from the next gap value so it drops on the accept edge.
  always_comb begin
    w_gap_next = r_gap;
    if (w_accept)
      w_gap_next = C_GAP;
    else if (r_gap != '0)
      w_gap_next = r_gap - GAP_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gap    <= '0;
      in_ready <= 1'b0;
    end else begin
      r_gap    <= w_gap_next;
      in_ready <= (w_gap_next == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_count  <= '0;
      err_count <= '0;
      last_src  <= '0;
      late      <= 1'b0;
    end else if (w_accept) begin
      if (rx_count != C_CNT_MAX)
        rx_count <= rx_count + CNT_W'(1);
      if (w_misroute && (err_count != C_CNT_MAX))
        err_count <= err_count + CNT_W'(1);
      last_src <= w_src;
      if (r_state == S_DONE)
        late <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_quiet <= '0;
    end else begin
      r_state <= w_state_next;
      r_quiet <= w_quiet_next;
    end
  end

  // An accept or a resumed send outranks the drain threshold on the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_quiet_next = '0;
    case (r_state)
      S_IDLE:  if (send) w_state_next = S_RUN;
      S_RUN:   if (!send) w_state_next = S_DRAIN;
      S_DRAIN: begin
        if (send)
          w_state_next = S_RUN;
        else if (!w_accept) begin
          if (w_quiet_hit)
            w_state_next = S_DONE;
          else
            w_quiet_next = r_quiet + QUIET_W'(1);
        end
      end
      S_DONE:  w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    done = (r_state == S_DONE);
  end

endmodule

`default_nettype wire

// File: tb/tb_async_sink.sv
// tb_async_sink: directed self-checking bench for async_sink. Rev 1.0
`default_nettype none

module tb_async_sink;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // d0: full rate, d1: READY_GAP=2, d2: 3-bit counters
  logic        send0 = 0, valid0 = 0, ready0, done0, late0;
  logic [31:0] data0 = '0;
  logic [15:0] rx0, err0;
  logic [3:0]  src0;

  logic        send1 = 0, valid1 = 0, ready1, done1, late1;
  logic [31:0] data1 = '0;
  logic [15:0] rx1, err1;
  logic [3:0]  src1;

  logic        send2 = 0, valid2 = 0, ready2, done2, late2;
  logic [31:0] data2 = '0;
  logic [2:0]  rx2, err2;
  logic [3:0]  src2;

  int total = 0;
  int passed = 0;

  async_sink #(.NODE_ID(5), .ADDR_W(4), .FLIT_W(32), .CNT_W(16), .READY_GAP(0), .COOLDOWN_IDLE(8)) d0 (
    .clk(clk), .reset(reset), .send(send0), .in_valid(valid0), .in_data(data0),
    .in_ready(ready0), .rx_count(rx0), .err_count(err0), .last_src(src0), .done(done0), .late(late0));

  async_sink #(.NODE_ID(5), .ADDR_W(4), .FLIT_W(32), .CNT_W(16), .READY_GAP(2), .COOLDOWN_IDLE(8)) d1 (
    .clk(clk), .reset(reset), .send(send1), .in_valid(valid1), .in_data(data1),
    .in_ready(ready1), .rx_count(rx1), .err_count(err1), .last_src(src1), .done(done1), .late(late1));

  async_sink #(.NODE_ID(5), .ADDR_W(4), .FLIT_W(32), .CNT_W(3), .READY_GAP(0), .COOLDOWN_IDLE(8)) d2 (
    .clk(clk), .reset(reset), .send(send2), .in_valid(valid2), .in_data(data2),
    .in_ready(ready2), .rx_count(rx2), .err_count(err2), .last_src(src2), .done(done2), .late(late2));

  function automatic logic [31:0] mk(input int dest, input int src);
    return {24'hA5C3E1, 4'(src), 4'(dest)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    send0 = 0; valid0 = 0; send1 = 0; valid1 = 0; send2 = 0; valid2 = 0;
    reset = 1;
    tick();
    tick();
    reset = 0;
    tick();
  endtask

  task automatic test_reset();
    send0 = 0; valid0 = 0;
    reset = 1;
    #2;
    total++; if ({ready0, done0, late0} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {ready0, done0, late0}); else passed++;
    total++; if ({rx0, err0, src0} !== 36'd0) $display("FAIL reset_counts: got %h expected 0", {rx0, err0, src0}); else passed++;
    tick();
    reset = 0;
    total++; if (ready0 !== 1'b0) $display("FAIL ready_before_edge: got %b expected 0", ready0); else passed++;
    tick();
    total++; if (ready0 !== 1'b1) $display("FAIL ready_after_release: got %b expected 1", ready0); else passed++;
  endtask

  task automatic test_back_to_back();
    int not_ready = 0;
    do_reset();
    send0 = 1; valid0 = 1; data0 = mk(5, 3);
    for (int i = 0; i < 10; i++) begin
      if (ready0 !== 1'b1) not_ready++;
      tick();
    end
    valid0 = 0;
    total++; if (not_ready !== 0) $display("FAIL b2b_ready: got %0d low cycles expected 0", not_ready); else passed++;
    total++; if (rx0 !== 16'd10) $display("FAIL b2b_rx: got %0d expected 10", rx0); else passed++;
    total++; if (err0 !== 16'd0) $display("FAIL b2b_err: got %0d expected 0", err0); else passed++;
    total++; if (src0 !== 4'd3) $display("FAIL b2b_last_src: got %0d expected 3", src0); else passed++;
  endtask

  task automatic test_misroute();
    do_reset();
    send0 = 1; valid0 = 1;
    for (int i = 0; i < 10; i++) begin
      data0 = (i % 2 == 0) ? mk(6, i) : mk(5, i);
      tick();
    end
    valid0 = 0;
    total++; if (rx0 !== 16'd10) $display("FAIL mis_rx: got %0d expected 10", rx0); else passed++;
    total++; if (err0 !== 16'd5) $display("FAIL mis_err: got %0d expected 5", err0); else passed++;
    total++; if (src0 !== 4'd9) $display("FAIL mis_last_src: got %0d expected 9", src0); else passed++;
  endtask

  task automatic test_gap();
    logic exp_ready;
    do_reset();
    valid1 = 1; data1 = mk(5, 1);
    for (int i = 0; i < 12; i++) begin
      exp_ready = (i % 3 == 0);
      total++; if (ready1 !== exp_ready) $display("FAIL gap_ready[%0d]: got %b expected %b", i, ready1, exp_ready); else passed++;
      tick();
    end
    valid1 = 0;
    total++; if (rx1 !== 16'd4) $display("FAIL gap_rx: got %0d expected 4", rx1); else passed++;
  endtask

  // Leaves d0 in the first DRAIN cycle with quiet count 0.
  task automatic enter_drain();
    do_reset();
    send0 = 1; tick();
    send0 = 0; tick();
  endtask

  task automatic check_window(input string name);
    int early = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (done0 !== 1'b0) early++;
    end
    total++; if (early !== 0) $display("FAIL %s_early: got %0d done cycles expected 0", name, early); else passed++;
    tick();
    total++; if (done0 !== 1'b1) $display("FAIL %s_done: got %b expected 1", name, done0); else passed++;
  endtask

  task automatic test_drain_flit();
    enter_drain();
    for (int i = 0; i < 5; i++) tick();
    valid0 = 1; data0 = mk(5, 7); tick(); valid0 = 0;
    total++; if (done0 !== 1'b0) $display("FAIL drain_flit_acc: got %b expected 0", done0); else passed++;
    check_window("drain_flit");
    total++; if ({rx0, late0} !== {16'd1, 1'b0}) $display("FAIL drain_flit_rx_late: got %0d/%b expected 1/0", rx0, late0); else passed++;
  endtask

  task automatic test_threshold_accept();
    enter_drain();
    for (int i = 0; i < 7; i++) tick();
    valid0 = 1; data0 = mk(5, 2); tick(); valid0 = 0;
    total++; if (done0 !== 1'b0) $display("FAIL thr_accept_wins: got %b expected 0", done0); else passed++;
    check_window("thr_accept");
  endtask

  task automatic test_resend_late();
    enter_drain();
    for (int i = 0; i < 6; i++) tick();
    send0 = 1; tick();
    send0 = 0; tick();
    check_window("resend");
    valid0 = 1; data0 = mk(5, 2); tick(); valid0 = 0;
    total++; if (late0 !== 1'b1) $display("FAIL late_flag: got %b expected 1", late0); else passed++;
    total++; if (rx0 !== 16'd1) $display("FAIL late_rx: got %0d expected 1", rx0); else passed++;
    send0 = 1; tick(); tick();
    total++; if (done0 !== 1'b1) $display("FAIL done_sticky: got %b expected 1", done0); else passed++;
    send0 = 0;
  endtask

  task automatic test_saturate_reset();
    do_reset();
    valid2 = 1;
    for (int i = 0; i < 9; i++) begin
      data2 = mk(5, i);
      tick();
    end
    valid2 = 0;
    total++; if (rx2 !== 3'd7) $display("FAIL sat_rx: got %0d expected 7", rx2); else passed++;
    total++; if (src2 !== 4'd8) $display("FAIL sat_last_src: got %0d expected 8", src2); else passed++;
    send2 = 1; tick();
    send2 = 0; tick();
    for (int i = 0; i < 8; i++) tick();
    total++; if (done2 !== 1'b1) $display("FAIL sat_done: got %b expected 1", done2); else passed++;
    #2 reset = 1;
    #1;
    total++; if ({ready2, done2, late2, rx2, err2, src2} !== 13'd0) $display("FAIL async_reset: got %h expected 0", {ready2, done2, late2, rx2, err2, src2}); else passed++;
    tick();
    reset = 0;
    tick();
    total++; if (ready2 !== 1'b1) $display("FAIL sat_ready_release: got %b expected 1", ready2); else passed++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_misroute();
    test_gap();
    test_drain_flit();
    test_threshold_accept();
    test_resend_late();
    test_saturate_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
